// File: rtl/sqrt_sa_pkg.sv
// Shared types and helpers for the successive-approximation square root unit.
package sqrt_sa_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    ROUND   = 2'd2,
    ERR     = 2'd3
  } state_t;

  function automatic int res_w(input int op_w);
    return op_w / 2;
  endfunction

endpackage

// File: rtl/sqrt_sa_param_if.sv
// go/done handshake bundle for sqrt_sa_param; the requester uses master,
// the sqrt unit uses slave.
interface sqrt_sa_param_if #(
  parameter int OP_W = 16
);
  localparam int RES_W = OP_W / 2;

  logic             go;
  logic [OP_W-1:0]  op;
  logic             busy;
  logic             done;
  logic             err;
  logic [RES_W-1:0] sqrt;
  logic [RES_W:0]   rem;

  modport master (
    output go, op,
    input  busy, done, err, sqrt, rem
  );

  modport slave (
    input  go, op,
    output busy, done, err, sqrt, rem
  );
endinterface

// File: rtl/sqrt_sa_dp.sv
// Datapath for the square root unit: latched operand, partial root, bit mask,
// trial-square compare and remainder. Rounding logic exists only with SQRT_SA_ROUND_EN.
module sqrt_sa_dp
  import sqrt_sa_pkg::*;
#(
  parameter int OP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     init,
  input  logic                     step,
  input  logic                     clear_out,
`ifdef SQRT_SA_ROUND_EN
  input  logic                     round,
`endif
  input  logic [OP_W-1:0]          op,
  output logic                     mask_lsb,
  output logic [res_w(OP_W)-1:0]   sqrt,
  output logic [res_w(OP_W):0]     rem
);

  localparam int RES_W = res_w(OP_W);

  logic [OP_W-1:0]  op_q;
  logic [RES_W-1:0] res;
  logic [RES_W-1:0] mask;
  logic [RES_W-1:0] trial;
  logic [RES_W-1:0] res_nxt;
  logic [OP_W-1:0]  trial_ext;
  logic [OP_W-1:0]  trial_sq;
  logic [RES_W:0]   res_ext;
  logic [RES_W:0]   res_sq_lo;
  logic [RES_W:0]   rem_nxt;

  // The remainder is bounded by 2*root, so only the low RES_W+1 bits of the
  // subtraction are needed; modular arithmetic keeps them exact.
  always_comb begin
    trial     = res | mask;
    trial_ext = {{(OP_W-RES_W){1'b0}}, trial};
    trial_sq  = trial_ext * trial_ext;
    res_nxt   = (trial_sq <= op_q) ? trial : res;
    res_ext   = {1'b0, res_nxt};
    res_sq_lo = res_ext * res_ext;
    rem_nxt   = op_q[RES_W:0] - res_sq_lo;
  end

  assign mask_lsb = mask[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= '0;
      res  <= '0;
      mask <= '0;
      sqrt <= '0;
      rem  <= '0;
    end else if (init) begin
      op_q <= op;
      res  <= '0;
      mask <= {1'b1, {(RES_W-1){1'b0}}};
    end else if (step) begin
      res  <= res_nxt;
      mask <= mask >> 1;
      if (mask[0]) begin
        sqrt <= res_nxt;
        rem  <= rem_nxt;
      end
    end else if (clear_out) begin
      sqrt <= '0;
      rem  <= '0;
    end
`ifdef SQRT_SA_ROUND_EN
    else if (round) begin
      // rem > res is the (res+0.5)^2 <= op test; saturate at the all-ones root.
      if ({1'b0, res} < rem) begin
        sqrt <= (&res) ? res : res + 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/sqrt_sa_param.sv
// Parametrised one-bit-per-clock integer square root with go/done handshake.
// Define SQRT_SA_ROUND_EN to add a round-to-nearest cycle after the compute phase.
module sqrt_sa_param
  import sqrt_sa_pkg::*;
#(
  parameter int OP_W   = 16,
  parameter int SIGNED = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  sqrt_sa_param_if.slave bus
);

  state_t state;
  state_t state_nxt;

  logic init;
  logic step;
  logic clear_out;
  logic round;
  logic set_done;
  logic set_err;
  logic clr_flags;
  logic mask_lsb;
  logic done_q;
  logic err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    init      = 1'b0;
    step      = 1'b0;
    clear_out = 1'b0;
    round     = 1'b0;
    set_done  = 1'b0;
    set_err   = 1'b0;
    clr_flags = 1'b0;
    case (state)
      IDLE: begin
        if (bus.go) begin
          init      = 1'b1;
          clr_flags = 1'b1;
          state_nxt = ((SIGNED != 0) && bus.op[OP_W-1]) ? ERR : COMPUTE;
        end
      end
      COMPUTE: begin
        step = 1'b1;
        if (mask_lsb) begin
`ifdef SQRT_SA_ROUND_EN
          state_nxt = ROUND;
`else
          set_done  = 1'b1;
          state_nxt = IDLE;
`endif
        end
      end
`ifdef SQRT_SA_ROUND_EN
      ROUND: begin
        round     = 1'b1;
        set_done  = 1'b1;
        state_nxt = IDLE;
      end
`endif
      ERR: begin
        clear_out = 1'b1;
        set_done  = 1'b1;
        set_err   = (SIGNED != 0);
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // done/err stay up until the next accepted go clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (clr_flags) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (set_done) done_q <= 1'b1;
      if (set_err)  err_q  <= 1'b1;
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.err  = (SIGNED != 0) ? err_q : 1'b0;

  sqrt_sa_dp #(
    .OP_W(OP_W)
  ) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .init      (init),
    .step      (step),
    .clear_out (clear_out),
`ifdef SQRT_SA_ROUND_EN
    .round     (round),
`endif
    .op        (bus.op),
    .mask_lsb  (mask_lsb),
    .sqrt      (bus.sqrt),
    .rem       (bus.rem)
  );

`ifndef SQRT_SA_ROUND_EN
  logic unused_round;
  assign unused_round = round;
`endif

endmodule

// File: tb/tb_sqrt_sa_param.sv
// Randomised self-checking bench for sqrt_sa_param: a signed and an unsigned
// instance (OP_W=16) compared against a plain-arithmetic square root model.
module tb_sqrt_sa_param;

  localparam int OP_W  = 16;
  localparam int RES_W = OP_W / 2;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   sel;

  sqrt_sa_param_if #(.OP_W(OP_W)) s_if ();
  sqrt_sa_param_if #(.OP_W(OP_W)) u_if ();

  sqrt_sa_param #(.OP_W(OP_W), .SIGNED(1)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (s_if)
  );

  sqrt_sa_param #(.OP_W(OP_W), .SIGNED(0)) dut_u (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  logic             cur_busy;
  logic             cur_done;
  logic             cur_err;
  logic [RES_W-1:0] cur_sqrt;
  logic [RES_W:0]   cur_rem;

  always_comb begin
    cur_busy = (sel == 0) ? s_if.busy : u_if.busy;
    cur_done = (sel == 0) ? s_if.done : u_if.done;
    cur_err  = (sel == 0) ? s_if.err  : u_if.err;
    cur_sqrt = (sel == 0) ? s_if.sqrt : u_if.sqrt;
    cur_rem  = (sel == 0) ? s_if.rem  : u_if.rem;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int floorSqrt(input int v);
    int s;
    s = 0;
    while ((s + 1) * (s + 1) <= v) s++;
    return s;
  endfunction

  function automatic int expRoot(input int v);
    int s;
    s = floorSqrt(v);
`ifdef SQRT_SA_ROUND_EN
    if (v - s * s > s) s = (s == (1 << RES_W) - 1) ? s : s + 1;
`endif
    return s;
  endfunction

  function automatic int expLatency(input bit neg);
    if (neg) return 1;
`ifdef SQRT_SA_ROUND_EN
    return RES_W + 1;
`else
    return RES_W;
`endif
  endfunction

  task automatic driveBus(input logic g, input logic [OP_W-1:0] o);
    if (sel == 0) begin
      s_if.go = g;
      s_if.op = o;
    end else begin
      u_if.go = g;
      u_if.op = o;
    end
  endtask

  // One full transaction: accept, optional noise on go/op while busy, then
  // result and latency against the model.
  task automatic applyStimulus(input int which, input logic [OP_W-1:0] value, input bit glitch);
    bit neg;
    int lat;
    int n;
    bit got;
    int es;
    int er;
    sel = which;
    neg = (which == 0) && value[OP_W-1];
    lat = expLatency(neg);
    es  = neg ? 0 : expRoot(int'(value));
    er  = neg ? 0 : int'(value) - floorSqrt(int'(value)) * floorSqrt(int'(value));
    @(negedge clk);
    driveBus(1'b1, value);
    @(posedge clk);
    #1;
    checkOutput("accept_done_clear", 32'(cur_done), 32'd0);
    checkOutput("accept_err_clear", 32'(cur_err), 32'd0);
    checkOutput("accept_busy", 32'(cur_busy), 32'd1);
    n   = 0;
    got = 1'b0;
    while (!got && n < lat + 4) begin
      @(negedge clk);
      if (glitch && (n + 1 < lat)) driveBus(1'($urandom_range(1)), OP_W'($urandom));
      else driveBus(1'b0, OP_W'($urandom));
      @(posedge clk);
      #1;
      n++;
      if (cur_done) got = 1'b1;
    end
    checkOutput("latency", 32'(n), 32'(lat));
    checkOutput("sqrt", 32'(cur_sqrt), 32'(es));
    checkOutput("rem", 32'(cur_rem), 32'(er));
    checkOutput("err", 32'(cur_err), 32'(neg));
    checkOutput("busy_after", 32'(cur_busy), 32'd0);
  endtask

  initial begin
    int highs;
    int run;
    int maxRun;
    int n;
    total = 0;
    bad   = 0;
    sel   = 0;
    s_if.go = 1'b0;
    s_if.op = '0;
    u_if.go = 1'b0;
    u_if.op = '0;
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 2; i++) begin
      sel = i;
      #1;
      checkOutput("reset_busy", 32'(cur_busy), 32'd0);
      checkOutput("reset_done", 32'(cur_done), 32'd0);
      checkOutput("reset_err", 32'(cur_err), 32'd0);
      checkOutput("reset_sqrt", 32'(cur_sqrt), 32'd0);
      checkOutput("reset_rem", 32'(cur_rem), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 16'd49, 1'b0);
    applyStimulus(0, 16'h7FFF, 1'b0);
    applyStimulus(0, 16'd0, 1'b0);
    applyStimulus(0, 16'hFFFC, 1'b0);
    applyStimulus(0, 16'd16, 1'b0);
    applyStimulus(0, 16'h8000, 1'b0);
    applyStimulus(1, 16'hFFFF, 1'b0);
    applyStimulus(1, 16'd56, 1'b0);
    applyStimulus(1, 16'd57, 1'b0);
    applyStimulus(1, 16'h8000, 1'b0);
    applyStimulus(1, 16'd0, 1'b0);
    applyStimulus(0, 16'd1000, 1'b1);
    applyStimulus(1, 16'd65000, 1'b1);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(int'($urandom_range(1)), OP_W'($urandom), 1'($urandom_range(1)));
    end

    // go held high: done must appear once per pass and last a single cycle.
    sel = 0;
    @(negedge clk);
    driveBus(1'b1, 16'd49);
    @(posedge clk);
    highs  = 0;
    run    = 0;
    maxRun = 0;
    for (int k = 0; k < 3 * (expLatency(1'b0) + 1); k++) begin
      @(posedge clk);
      #1;
      if (cur_done) begin
        highs++;
        run++;
        if (run > maxRun) maxRun = run;
      end else begin
        run = 0;
      end
    end
    checkOutput("held_go_done_count", 32'(highs), 32'd3);
    checkOutput("held_go_done_width", 32'(maxRun), 32'd1);
    @(negedge clk);
    driveBus(1'b0, 16'd0);
    n = 0;
    while (!cur_done && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("held_go_final_done", 32'(cur_done), 32'd1);
    checkOutput("held_go_final_sqrt", 32'(cur_sqrt), 32'd7);

    // Reset in the middle of a computation abandons it.
    sel = 0;
    @(negedge clk);
    driveBus(1'b1, 16'd100);
    @(posedge clk);
    @(negedge clk);
    driveBus(1'b0, 16'd100);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 32'(cur_busy), 32'd0);
    checkOutput("midreset_done", 32'(cur_done), 32'd0);
    checkOutput("midreset_sqrt", 32'(cur_sqrt), 32'd0);
    checkOutput("midreset_rem", 32'(cur_rem), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    highs = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (cur_done || cur_busy) highs++;
    end
    checkOutput("midreset_no_done", 32'(highs), 32'd0);

    applyStimulus(0, 16'd144, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sqrt_sa_param.md
Name: sqrt_sa_param

Overview:
Parametrised successive-approximation integer square root, one result bit per clock. It is the next generation of the team's fixed 16-bit sqrt unit. Additions over that unit:
- configurable operand width
- signed or unsigned operand mode
- operand latched at start
- remainder output
- busy indication
- optional round-to-nearest

It serves as a shared arithmetic helper for control and datapath blocks that need a multi-cycle sqrt with a go/done handshake.

Parameters:
OP_W, 16, operand width in bits; must be even and >= 4. Derived localparam RES_W = OP_W/2.
SIGNED, 1, 1 = op is two's complement, negative sets err; 0 = op is unsigned.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
go  input  1  start request, level-sampled; accepted only in IDLE
op  input  OP_W  operand; sampled only on the accepting edge
busy  output  1  high while not in IDLE
done  output  1  result valid; held until the next accepted go
err  output  1  negative operand (SIGNED=1 only); held with done
sqrt  output  RES_W  floor(sqrt(op)), or rounded when the option is on
rem  output  RES_W+1  op - floor(sqrt)^2, always for the truncated root

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, err, sqrt, rem, and the internal mask/op registers all clear to 0. Reset mid-computation abandons the operation; no done is produced.
- States (package enum): IDLE, COMPUTE, ROUND (only with option), ERR.
- IDLE with go=1 (accepting edge):
  - Latch op into op_q; clear done and err; res=0; mask=1<<(RES_W-1).
  - Next state is ERR if SIGNED=1 and op[OP_W-1]=1, else COMPUTE.
- COMPUTE, each edge:
  - trial = res|mask. res <= (trial*trial <= op_q) ? trial : res. mask >>= 1.
  - Product is a full OP_W-bit unsigned compare; no truncation.
  - On the edge where mask[0] is processed: load sqrt=final res and rem=op_q-res^2. Set done; go to IDLE (or ROUND if the option is on).
- Latency without option: done rises exactly RES_W clock edges after the accepting edge (8 for OP_W=16). busy is high for those RES_W cycles.
- ERR: one cycle. Next edge sets done=1, err=1, sqrt=0, rem=0; go to IDLE. Error latency is 1 edge.
- go while busy is ignored (no queuing). op changes after the accepting edge are ignored.
- go held high in IDLE restarts on every return to IDLE. done is then visible for exactly one cycle, since the next accepting edge clears it.
- op=0 gives sqrt=0, rem=0. Unsigned maximum (2^OP_W-1) gives sqrt=2^RES_W-1, rem=2^(RES_W+1)-2. rem never exceeds 2*sqrt, so RES_W+1 bits is sufficient.
- With SIGNED=0 the MSB is magnitude and err is tied 0; the ERR state is unreachable.

Optional Feature:
Macro SQRT_SA_ROUND_EN.
- Defined:
  - After COMPUTE, one extra ROUND cycle runs before done.
  - If rem > res, sqrt = res+1, saturated at 2^RES_W-1; else sqrt = res. This implements the (s+0.5)^2 test.
  - rem still reports op - res^2 for the truncated res.
  - Latency becomes RES_W+1. The error path is unchanged.
- Undefined: ROUND state and logic are absent; truncating behaviour as above.

Decomposition:
- Package sqrt_sa_pkg: state_t enum {IDLE, COMPUTE, ROUND, ERR}, and function res_w(op_w) returning op_w/2.
- One natural sub-module, sqrt_sa_dp. It holds the datapath: op_q, res, mask, the trial-square compare, and rem subtraction, with init/update/load controls. The FSM and done/err flags stay in the top.

Test Plan:
- OP_W=16, SIGNED=1, op=49, go pulse -> busy for 8 cycles; done=1 on 8th edge after accept; sqrt=7, rem=0, err=0.
- op=0x7FFF -> sqrt=181, rem=6, done after 8 edges. Then op=0 -> sqrt=0, rem=0, and done deasserts on the accepting edge.
- SIGNED=1, op=0xFFFC -> done=1, err=1 one edge after accept; sqrt=0. A following go with op=16 -> err clears on accept; sqrt=4.
- SIGNED=0, op=0xFFFF -> sqrt=255, rem=510, err=0. With SQRT_SA_ROUND_EN: sqrt stays 255 (saturated), latency 9.
- SQRT_SA_ROUND_EN, op=56 -> sqrt=7, rem=7. op=57 -> sqrt=8, rem=8.
- Robustness checks:
  - go and op toggled during COMPUTE -> ignored; result is for the original op.
  - rst_n low mid-COMPUTE -> all outputs 0 and IDLE immediately; no done afterwards until a new go.
